// File: rtl/kpg_sub_unit.sv
// Two-stage pipelined subtractor D = A - B = A + ~B + 1 on a KPG recursive-doubling carry network.
// Optional flag outputs (zero/neg/ovf) are built when KPG_SUB_FLAGS_EN is defined.
module kpg_sub_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_borrow,
`ifdef KPG_SUB_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             adv;
  logic             accept;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] in_g;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] cg;
  logic [WIDTH-1:0] cp;
  logic [WIDTH-1:0] ng;
  logic [WIDTH-1:0] np;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] d_next;
  logic             borrow_next;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | adv;
  assign accept   = in_valid & in_ready;

  // With carry-in fixed at 1, bit 0 emits a carry unless it kills, so its
  // pair is folded into a generate and the prefix spans only WIDTH positions.
  assign nb   = ~in_b;
  assign in_p = in_a ^ nb;
  always_comb begin
    in_g    = in_a & nb;
    in_g[0] = (in_a[0] & nb[0]) | in_p[0];
  end

  // NOTE: every combinational output gets a default before the loops so no
  // path through the block can leave a value held, which would infer a latch.
  always_comb begin
    cg = s1_g;
    cp = s1_p;
    ng = '0;
    np = '0;
    for (int l = 0; l < LEVELS; l++) begin
      ng = cg;
      np = cp;
      for (int i = (1 << l); i < WIDTH; i++) begin
        ng[i] = cg[i] | (cp[i] & cg[i - (1 << l)]);
        np[i] = cp[i] & cp[i - (1 << l)];
      end
      cg = ng;
      cp = np;
    end
    carry       = {cg, 1'b1};
    d_next      = s1_p ^ carry[WIDTH-1:0];
    borrow_next = ~carry[WIDTH];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_g     <= in_g;
      s1_p     <= in_p;
      s1_tag   <= in_tag;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_d      <= '0;
      out_borrow <= 1'b0;
      out_tag    <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_d      <= d_next;
        out_borrow <= borrow_next;
        out_tag    <= s1_tag;
      end
    end
  end

`ifdef KPG_SUB_FLAGS_EN
  logic zero_next;
  logic neg_next;
  logic ovf_next;

  // A zero propagate bit at the msb means A and ~B agree there, i.e. A and B
  // differ in sign, and the generate bit then equals A's sign.
  assign zero_next = (d_next == '0);
  assign neg_next  = d_next[WIDTH-1];
  assign ovf_next  = ~s1_p[WIDTH-1] & (d_next[WIDTH-1] != s1_g[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (adv && s1_valid) begin
      out_zero <= zero_next;
      out_neg  <= neg_next;
      out_ovf  <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_kpg_sub_unit.sv
// Scoreboard bench for kpg_sub_unit: expected results are queued on accept and
// compared as the unit hands them over on the writeback side.
module tb_kpg_sub_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d;
  logic        out_borrow;
  logic [3:0]  out_tag;
`ifdef KPG_SUB_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
  logic        out_ovf;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        borrow;
    logic [3:0]  tag;
    logic        zero;
    logic        neg;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  kpg_sub_unit #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .out_borrow(out_borrow),
`ifdef KPG_SUB_FLAGS_EN
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    res_t r;
    r.d      = a - b;
    r.borrow = (a < b);
    r.tag    = t;
    r.zero   = 1'b0;
    r.neg    = 1'b0;
    r.ovf    = 1'b0;
`ifdef KPG_SUB_FLAGS_EN
    r.zero = (r.d == 32'd0);
    r.neg  = r.d[31];
    r.ovf  = (a[31] != b[31]) && (r.d[31] != a[31]);
`endif
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    r.d      = out_d;
    r.borrow = out_borrow;
    r.tag    = out_tag;
    r.zero   = 1'b0;
    r.neg    = 1'b0;
    r.ovf    = 1'b0;
`ifdef KPG_SUB_FLAGS_EN
    r.zero = out_zero;
    r.neg  = out_neg;
    r.ovf  = out_ovf;
`endif
    return r;
  endfunction

  // Drive one cycle of stimulus just after the rising edge, then sample at the
  // falling edge what the next rising edge will transfer on each side.
  task automatic tick(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic ordy,
                      output logic acc, output logic got, output res_t obs);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
    acc = in_valid & in_ready;
    if (acc) exp_q.push_back(model(a, b, t));
    got = out_valid & out_ready;
    obs = observe();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    total++;
    if ({out_valid, out_d, out_borrow, out_tag} !== 38'd0)
      $display("FAIL reset_outputs: got v=%0b d=%h b=%0b t=%0d, want all 0", out_valid, out_d, out_borrow, out_tag);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_arith();
    logic [31:0] av [6] = '{32'd5, 32'd3, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000};
    logic [31:0] bv [6] = '{32'd3, 32'd5, 32'd1,          32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF};
    logic [3:0]  tv [6] = '{4'd2,  4'd3,  4'd4,           4'd5,          4'd6,          4'd7};
    logic acc, got;
    res_t obs, e;
    for (int k = 0; k < 6; k++) begin
      int lat;
      tick(1'b1, av[k], bv[k], tv[k], 1'b1, acc, got, obs);
      total++;
      if (!acc) $display("FAIL arith_accept_%0d: in_ready=0 want 1", k);
      else passed++;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        tick(1'b0, '0, '0, '0, 1'b1, acc, got, obs);
        lat++;
      end
      total++;
      if (!got || exp_q.size() == 0) begin
        $display("FAIL arith_timeout_%0d: no result after %0d cycles", k, lat);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) $display("FAIL arith_%0d: got %h want %h", k, obs, e);
        else passed++;
      end
      if (k == 0) begin
        total++;
        if (lat !== 2) $display("FAIL latency: got %0d idle cycles want 2", lat);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, got;
    res_t obs, e;
    int first, last, nout, cyc;
    first = -1; last = -1; nout = 0; cyc = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 32'h1000_0000 * k + 32'd77, 32'd1000 * k, k[3:0], 1'b1, acc, got, obs);
      if (!acc) $display("FAIL b2b_accept_%0d: in_ready=0 want 1", k);
      if (got) begin
        if (first < 0) first = cyc;
        last = cyc; nout++;
        total++;
        e = exp_q.pop_front();
        if (obs !== e) $display("FAIL b2b_result: got %h want %h", obs, e);
        else passed++;
      end
      cyc++;
    end
    while (exp_q.size() != 0 && cyc < 20) begin
      tick(1'b0, '0, '0, '0, 1'b1, acc, got, obs);
      if (got) begin
        if (first < 0) first = cyc;
        last = cyc; nout++;
        total++;
        e = exp_q.pop_front();
        if (obs !== e) $display("FAIL b2b_result: got %h want %h", obs, e);
        else passed++;
      end
      cyc++;
    end
    total++;
    if (nout !== 8) $display("FAIL b2b_count: got %0d results want 8", nout);
    else passed++;
    total++;
    if (last - first + 1 !== 8) $display("FAIL b2b_consecutive: span %0d cycles want 8", last - first + 1);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic acc, got;
    res_t obs, e, held;
    int nacc, cyc;
    logic rdy_seen;
    nacc = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 32'hA000_0000 + nacc, 32'h0100_0000 * (nacc + 1), 4'(8 + nacc), 1'b0, acc, got, obs);
      rdy_seen = in_ready;
      if (acc) nacc++;
      if (k == 2) held = obs;
      if (k == 3) begin
        total++;
        if (rdy_seen !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", rdy_seen);
        else passed++;
        total++;
        if (obs !== held || out_valid !== 1'b1)
          $display("FAIL bp_stable: got %h v=%b want %h v=1", obs, out_valid, held);
        else passed++;
      end
    end
    total++;
    if (nacc !== 2) $display("FAIL bp_accepts: got %0d want 2", nacc);
    else passed++;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      tick(1'b0, '0, '0, '0, 1'b1, acc, got, obs);
      if (got) begin
        total++;
        e = exp_q.pop_front();
        if (obs !== e) $display("FAIL bp_drain: got %h want %h", obs, e);
        else passed++;
      end
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL bp_lost: %0d results never arrived, want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic acc, got;
    res_t obs, e;
    int cyc, nout;
    for (int k = 0; k < 2; k++)
      tick(1'b1, 32'h5555_0000 + k, 32'h0000_1111, 4'(12 + k), 1'b0, acc, got, obs);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_d, out_borrow, out_tag} !== 38'd0)
      $display("FAIL midreset_outputs: got v=%0b d=%h b=%0b t=%0d, want all 0", out_valid, out_d, out_borrow, out_tag);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b want 1", in_ready);
    else passed++;
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 32'd100, 32'd58, 4'd9, 1'b1, acc, got, obs);
    cyc = 0; nout = 0;
    while (cyc < 6) begin
      tick(1'b0, '0, '0, '0, 1'b1, acc, got, obs);
      if (got) begin
        nout++;
        total++;
        if (exp_q.size() == 0) $display("FAIL midreset_stale: unexpected result %h", obs);
        else begin
          e = exp_q.pop_front();
          if (obs !== e) $display("FAIL midreset_result: got %h want %h", obs, e);
          else passed++;
        end
      end
      cyc++;
    end
    total++;
    if (nout !== 1) $display("FAIL midreset_count: got %0d results want 1", nout);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) $display("FAIL final_queue: %0d pending want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
